tc_dn: RTL and testbench

Operand distribution network for the tensor-core tile datapath. It accepts an A tile (TILE_M×TILE_K) row by row and a B tile (TILE_K×TILE_N) row by row over two independent valid/ready streams, buffers both, and presents the fully expanded operand vectors to the TILE_M·TILE_K·TILE_N multiplier array. Lane order matches the downstream reduction network, so product lane outputs feed the per-row adder trees directly.

---
 rtl/tc_pkg.sv | 20 ++
 rtl/tc_dn_if.sv | 27 ++
 rtl/tc_dn_loader.sv | 61 ++++++
 rtl/tc_dn.sv | 121 ++++++++++++
 tb/tb_tc_dn.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pkg.sv
// tc_dn shared package: tile geometry, element width, lane index, FSM states.
// Optional ping-pong buffering is selected with TC_DN_DBUF_EN.
package tc_pkg;

  localparam int TILE_M  = 4;
  localparam int TILE_K  = 8;
  localparam int TILE_N  = 4;
  localparam int DW_DATA = 8;
  localparam int NUM_IN  = TILE_M * TILE_K * TILE_N;

  typedef enum logic {
    FILL,
    OUT
  } tc_state_e;

  function automatic int p(int m, int k, int n);
    return (m * TILE_K + k) * TILE_N + n;
  endfunction

endpackage

// File: rtl/tc_dn_if.sv
// tc_dn stream bundle: A rows, B rows and the expanded operand output.
// master drives rows and out_ready; slave is the distribution network.
interface tc_dn_if;
  import tc_pkg::*;

  logic                        a_valid;
  logic                        a_ready;
  logic [TILE_K*DW_DATA-1:0]   a_row;
  logic                        b_valid;
  logic                        b_ready;
  logic [TILE_N*DW_DATA-1:0]   b_row;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_IN*DW_DATA-1:0]   a_out;
  logic [NUM_IN*DW_DATA-1:0]   b_out;

  modport master (
    output a_valid, a_row, b_valid, b_row, out_ready,
    input  a_ready, b_ready, out_valid, a_out, b_out
  );

  modport slave (
    input  a_valid, a_row, b_valid, b_row, out_ready,
    output a_ready, b_ready, out_valid, a_out, b_out
  );

endinterface

// File: rtl/tc_dn_loader.sv
// Row loader: counter, row-indexed buffer, full flag and ready.
// With TC_DN_DBUF_EN, rows presents next-state buffer for bank swap.
module tc_dn_loader #(
  parameter int ROWS  = 4,
  parameter int ROW_W = 8,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [ROW_W*DW-1:0]      row,
  input  logic                     hold,
  input  logic                     clr,
  output logic                     ready,
  output logic                     done,
  output logic [ROWS*ROW_W*DW-1:0] rows
);

  localparam int CW = $clog2(ROWS);
  localparam int RW = ROW_W * DW;

  logic [CW-1:0]      cnt;
  logic               full;
  logic               full_d;
  logic               fire;
  logic               last;
  logic [ROWS*RW-1:0] mem;
  logic [ROWS*RW-1:0] mem_d;

  assign ready = ~full & ~hold;
  assign fire  = valid & ready;
  assign last  = cnt == CW'(ROWS - 1);
  assign done  = full | (fire & last);

  always_comb begin
    mem_d = mem;
    if (fire)
      mem_d[int'(cnt)*RW +: RW] = row;
    full_d = clr ? 1'b0 : done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      full <= 1'b0;
      mem  <= '0;
    end else begin
      mem  <= mem_d;
      full <= full_d;
      if (fire)
        cnt <= last ? '0 : cnt + 1'b1;
    end
  end

`ifdef TC_DN_DBUF_EN
  assign rows = mem_d;
`else
  assign rows = mem;
`endif

endmodule

// File: rtl/tc_dn.sv
// tc_dn operand distribution network top: two loaders, FSM, lane fan-out.
// TC_DN_DBUF_EN adds a separate output bank so loading overlaps output.
module tc_dn
  import tc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  tc_dn_if.slave  bus
);

  localparam int AW = TILE_M * TILE_K * DW_DATA;
  localparam int BW = TILE_K * TILE_N * DW_DATA;

  tc_state_e state;
  tc_state_e state_d;

  logic a_done;
  logic b_done;
  logic hold;
  logic clr;
  logic ho;
  logic swap;

  logic [AW-1:0] a_rows;
  logic [AW-1:0] a_ob;
  logic [BW-1:0] b_rows;
  logic [BW-1:0] b_ob;

  logic [NUM_IN*DW_DATA-1:0] a_lane;
  logic [NUM_IN*DW_DATA-1:0] b_lane;

  assign bus.out_valid = state == OUT;
  assign ho            = bus.out_valid & bus.out_ready;

  tc_dn_loader #(
    .ROWS  (TILE_M),
    .ROW_W (TILE_K),
    .DW    (DW_DATA)
  ) u_a (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.a_valid),
    .row   (bus.a_row),
    .hold  (hold),
    .clr   (clr),
    .ready (bus.a_ready),
    .done  (a_done),
    .rows  (a_rows)
  );

  tc_dn_loader #(
    .ROWS  (TILE_K),
    .ROW_W (TILE_N),
    .DW    (DW_DATA)
  ) u_b (
    .clk   (clk),
    .rst   (rst),
    .valid (bus.b_valid),
    .row   (bus.b_row),
    .hold  (hold),
    .clr   (clr),
    .ready (bus.b_ready),
    .done  (b_done),
    .rows  (b_rows)
  );

`ifdef TC_DN_DBUF_EN
  assign hold = 1'b0;
  assign swap = a_done & b_done & ((state == FILL) | ho);
  assign clr  = swap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_ob <= '0;
      b_ob <= '0;
    end else if (swap) begin
      a_ob <= a_rows;
      b_ob <= b_rows;
    end
  end
`else
  assign hold = state == OUT;
  assign swap = a_done & b_done & (state == FILL);
  assign clr  = ho;
  assign a_ob = a_rows;
  assign b_ob = b_rows;
`endif

  // swap wins over handoff: a refilled bank keeps out_valid high
  always_comb begin
    state_d = state;
    if (swap)
      state_d = OUT;
    else if (ho)
      state_d = FILL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FILL;
    else
      state <= state_d;
  end

  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int m = 0; m < TILE_M; m++)
      for (int k = 0; k < TILE_K; k++)
        for (int n = 0; n < TILE_N; n++) begin
          a_lane[p(m, k, n)*DW_DATA +: DW_DATA] =
            a_ob[(m*TILE_K+k)*DW_DATA +: DW_DATA];
          b_lane[p(m, k, n)*DW_DATA +: DW_DATA] =
            b_ob[(k*TILE_N+n)*DW_DATA +: DW_DATA];
        end
  end

  assign bus.a_out = a_lane;
  assign bus.b_out = b_lane;

endmodule

// File: tb/tb_tc_dn.sv
// Directed bench for tc_dn: reset, identity, skew, backpressure, random, period.
// Build with TC_DN_DBUF_EN to exercise the ping-pong variant.
module tb_tc_dn;
  import tc_pkg::*;

`ifdef TC_DN_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  localparam int AR = TILE_K * 8;
  localparam int BR = TILE_N * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc_dn_if bus ();

  tc_dn dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] am [TILE_M][TILE_K];
  logic [7:0] bm [TILE_K][TILE_N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_row   = '0;
    bus.b_row   = '0;
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b0;
    #3;
    @(negedge clk) rst = 1'b1;
  endtask

  function automatic logic [AR-1:0] arow(int m);
    logic [AR-1:0] r;
    r = '0;
    if (m < TILE_M)
      for (int k = 0; k < TILE_K; k++) r[k*8 +: 8] = am[m][k];
    return r;
  endfunction

  function automatic logic [BR-1:0] brow(int k);
    logic [BR-1:0] r;
    r = '0;
    if (k < TILE_K)
      for (int n = 0; n < TILE_N; n++) r[n*8 +: 8] = bm[k][n];
    return r;
  endfunction

  function automatic int lane_bad(output int first);
    int cnt;
    int q;
    cnt   = 0;
    first = -1;
    for (int m = 0; m < TILE_M; m++)
      for (int k = 0; k < TILE_K; k++)
        for (int n = 0; n < TILE_N; n++) begin
          q = (m * TILE_K + k) * TILE_N + n;
          if (bus.a_out[q*8 +: 8] !== am[m][k] ||
              bus.b_out[q*8 +: 8] !== bm[k][n]) begin
            if (first < 0) first = q;
            cnt++;
          end
        end
    return cnt;
  endfunction

  task automatic load_tile(output bit ok, output bit early);
    int ai = 0;
    int bi = 0;
    bit acc_a;
    bit acc_b;
    early = 1'b0;
    for (int c = 0; c < 60 && !(ai == TILE_M && bi == TILE_K); c++) begin
      if (bus.out_valid) early = 1'b1;
      bus.a_valid = ai < TILE_M;
      bus.a_row   = arow(ai);
      bus.b_valid = bi < TILE_K;
      bus.b_row   = brow(bi);
      acc_a = bus.a_valid & bus.a_ready;
      acc_b = bus.b_valid & bus.b_ready;
      tick();
      if (acc_a) ai++;
      if (acc_b) bi++;
    end
    idle();
    ok = (ai == TILE_M) && (bi == TILE_K);
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    idle();
    rst = 1'b0;
    #12;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (bus.a_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_a_ready pass %0d got %b want 1", pass, bus.a_ready);
      end
      checks++;
      if (bus.b_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_b_ready pass %0d got %b want 1", pass, bus.b_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid pass %0d got %b want 0", pass, bus.out_valid);
      end
      checks++;
      if (bus.a_out !== '0) begin
        errors++;
        $display("FAIL reset_a_out pass %0d got nonzero want 0", pass);
      end
      checks++;
      if (bus.b_out !== '0) begin
        errors++;
        $display("FAIL reset_b_out pass %0d got nonzero want 0", pass);
      end
      if (pass == 0) begin
        @(negedge clk) rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
          bus.a_valid = i < 2;
          bus.a_row   = {TILE_K{8'h5a}};
          bus.b_valid = 1'b1;
          bus.b_row   = {TILE_N{8'ha5}};
          tick();
        end
        idle();
        #3 rst = 1'b0;
        #1;
      end
    end
    @(negedge clk) rst = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    bit ok;
    bit early;
    int nb;
    int fb;
    for (int m = 0; m < TILE_M; m++)
      for (int k = 0; k < TILE_K; k++) am[m][k] = 8'(m * 16 + k);
    for (int k = 0; k < TILE_K; k++)
      for (int n = 0; n < TILE_N; n++) bm[k][n] = 8'(k * 16 + n);
    bus.out_ready = 1'b1;
    load_tile(ok, early);
    checks++;
    if (!ok || early) begin
      errors++;
      $display("FAIL ident_load got ok=%b early=%b want ok=1 early=0", ok, early);
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ident_out_valid got %b want 1", bus.out_valid);
    end
    nb = lane_bad(fb);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL ident_lanes got %0d bad lanes first %0d want 0", nb, fb);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL ident_handoff got ov=%b ar=%b br=%b want 0 1 1",
               bus.out_valid, bus.a_ready, bus.b_ready);
    end
  endtask

  task automatic test_skewed();
    bit stall_ok = 1'b1;
    int nb;
    int fb;
    for (int m = 0; m < TILE_M; m++)
      for (int k = 0; k < TILE_K; k++) am[m][k] = 8'(8'h40 + m * 8 + k);
    for (int k = 0; k < TILE_K; k++)
      for (int n = 0; n < TILE_N; n++) bm[k][n] = 8'(8'h80 + k * 4 + n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < TILE_M; i++) begin
      bus.a_valid = 1'b1;
      bus.a_row   = arow(i);
      tick();
    end
    bus.a_row = {TILE_K{8'hff}};
    checks++;
    if (bus.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL skew_a_full got a_ready=%b want 0", bus.a_ready);
    end
    for (int k = 0; k < TILE_K; k++) begin
      bus.b_valid = 1'b1;
      bus.b_row   = brow(k);
      tick();
      bus.b_valid = 1'b0;
      if (k < TILE_K - 1) begin
        for (int w = 0; w < 2; w++) begin
          if (bus.out_valid !== 1'b0 || bus.a_ready !== 1'b0) stall_ok = 1'b0;
          tick();
        end
      end
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL skew_wait got early out_valid or a_ready want both 0");
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skew_out_valid got %b want 1", bus.out_valid);
    end
    nb = lane_bad(fb);
    checks++;
    if (nb !== 0) begin
      errors++;
      $display("FAIL skew_lanes got %0d bad lanes first %0d want 0", nb, fb);
    end
    bus.a_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit early;
    int nb;
    int fb;
    for (int m = 0; m < TILE_M; m++)
      for (int k = 0; k < TILE_K; k++) am[m][k] = 8'(m * 37 + k * 5 + 3);
    for (int k = 0; k < TILE_K; k++)
      for (int n = 0; n < TILE_N; n++) bm[k][n] = 8'(k * 11 + n * 7 + 1);
    bus.out_ready = 1'b0;
    load_tile(ok, early);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_load got timeout want tile loaded");
    end
    for (int c = 0; c < 10; c++) begin
      nb = lane_bad(fb);
      checks++;
      if (bus.out_valid !== 1'b1 || nb !== 0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ov=%b bad=%0d want ov=1 bad=0",
                 c, bus.out_valid, nb);
      end
      tick();
    end
    checks++;
    if (bus.a_ready !== DBUF) begin
      errors++;
      $display("FAIL bp_a_ready got %b want %b", bus.a_ready, DBUF);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got ov=%b ar=%b br=%b want 0 1 1",
               bus.out_valid, bus.a_ready, bus.b_ready);
    end
  endtask

  task automatic test_random();
    logic [AR-1:0] aq [$];
    logic [BR-1:0] bq [$];
    logic [AR-1:0] ra;
    logic [BR-1:0] rb;
    int tiles = 0;
    int drops = 0;
    bit acc_a;
    bit acc_b;
    bit hs;
    bit prev_ov = 1'b0;
    bit prev_hs = 1'b0;
    int nb;
    int fb;
    do_reset();
    for (int c = 0; c < 30000 && tiles < 200; c++) begin
      if (prev_ov && !prev_hs && !bus.out_valid) drops++;
      if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
        bus.a_valid = 1'b1;
        bus.a_row   = {$urandom(), $urandom()};
      end
      if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
        bus.b_valid = 1'b1;
        bus.b_row   = $urandom();
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      acc_a = bus.a_valid & bus.a_ready;
      acc_b = bus.b_valid & bus.b_ready;
      hs    = bus.out_valid & bus.out_ready;
      if (hs) begin
        checks++;
        if (aq.size() < TILE_M || bq.size() < TILE_K) begin
          errors++;
          $display("FAIL rand_rows tile %0d got a=%0d b=%0d rows want %0d %0d",
                   tiles, aq.size(), bq.size(), TILE_M, TILE_K);
        end else begin
          for (int m = 0; m < TILE_M; m++) begin
            ra = aq.pop_front();
            for (int k = 0; k < TILE_K; k++) am[m][k] = ra[k*8 +: 8];
          end
          for (int k = 0; k < TILE_K; k++) begin
            rb = bq.pop_front();
            for (int n = 0; n < TILE_N; n++) bm[k][n] = rb[n*8 +: 8];
          end
          nb = lane_bad(fb);
          if (nb !== 0) begin
            errors++;
            $display("FAIL rand_tile %0d got %0d bad lanes first %0d want 0",
                     tiles, nb, fb);
          end
        end
        tiles++;
      end
      if (acc_a) aq.push_back(bus.a_row);
      if (acc_b) bq.push_back(bus.b_row);
      prev_ov = bus.out_valid;
      prev_hs = hs;
      tick();
      if (acc_a) bus.a_valid = 1'b0;
      if (acc_b) bus.b_valid = 1'b0;
    end
    idle();
    bus.out_ready = 1'b0;
    checks++;
    if (tiles !== 200) begin
      errors++;
      $display("FAIL rand_count got %0d tiles want 200", tiles);
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL rand_drop got %0d unhandshaken drops want 0", drops);
    end
  endtask

  task automatic test_period();
    int rises [$];
    bit prev = 1'b0;
    int exp_per;
    exp_per = DBUF ? 8 : 9;
    do_reset();
    bus.out_ready = 1'b1;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_row     = {TILE_K{8'h11}};
    bus.b_row     = {TILE_N{8'h22}};
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (bus.out_valid && !prev) rises.push_back(c);
      prev = bus.out_valid;
    end
    idle();
    checks++;
    if (rises.size() < 5) begin
      errors++;
      $display("FAIL period_count got %0d tiles want >=5", rises.size());
    end else begin
      checks++;
      if (rises[0] !== 8) begin
        errors++;
        $display("FAIL period_first got edge %0d want 8", rises[0]);
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (rises[i] - rises[i-1] !== exp_per) begin
          errors++;
          $display("FAIL period_gap %0d got %0d want %0d",
                   i, rises[i] - rises[i-1], exp_per);
        end
      end
    end
  endtask

`ifdef TC_DN_DBUF_EN
  task automatic test_dbuf_stall();
    bit early_ok = 1'b1;
    do_reset();
    bus.out_ready = 1'b0;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_row     = {TILE_K{8'h33}};
    bus.b_row     = {TILE_N{8'h44}};
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c >= 9 && c <= 15 && bus.b_ready !== 1'b1) early_ok = 1'b0;
    end
    checks++;
    if (!early_ok) begin
      errors++;
      $display("FAIL dbuf_second_fill got b_ready low early want 1");
    end
    checks++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL dbuf_stall got ar=%b br=%b ov=%b want 0 0 1",
               bus.a_ready, bus.b_ready, bus.out_valid);
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_skewed();
    test_backpressure();
    test_random();
    test_period();
`ifdef TC_DN_DBUF_EN
    test_dbuf_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
